// File: rtl/result_to_display.sv
// result_to_display
//   Converts a 27-bit unsigned binary result into eight BCD digits using a
//   serial double-dabble loop, then writes the digits to the display stage
//   one position per cycle, from units (pos 0) up to the most significant
//   digit (pos 7). If the value is above 99_999_999, the conversion is skipped
//   and eight zeros are written with ovf raised.
//
// Ports
//   clock  : single clock, rising edge
//   reset  : asynchronous, active-low reset
//   start  : convert/display request, sampled only while idle
//   value  : unsigned binary result to display (27 bits)
//   busy   : high whenever the block is not idle
//   done   : one-cycle pulse after the last digit write
//   ovf    : value exceeded eight decimal digits; held until the next start
//   dig    : BCD digit being written, 0 when not writing
//   pos    : digit position being written, IDLE_POS when not writing
module result_to_display #(
  parameter logic [3:0] IDLE_POS = 4'd15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [26:0] value,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  dig,
  output logic [3:0]  pos
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [26:0] MAX_DEC   = 27'd99_999_999;
  localparam logic [4:0]  LAST_STEP = 5'd26;
  localparam logic [2:0]  LAST_IDX  = 3'd7;

  state_t      state;
  state_t      state_nxt;
  logic [26:0] bin;
  logic [31:0] bcd;
  logic [4:0]  step;
  logic [2:0]  idx;
  logic        value_ovf;

  // Add 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [31:0] dabble_adjust(input logic [31:0] b);
    logic [31:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign value_ovf = (value > MAX_DEC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = value_ovf ? WRITE : CONV;
      CONV:    if (step == LAST_STEP) state_nxt = WRITE;
      WRITE:   if (idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bin  <= '0;
      bcd  <= '0;
      step <= '0;
      idx  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == WRITE) && (idx == LAST_IDX);
      case (state)
        IDLE: begin
          if (start) begin
            bin  <= value;
            bcd  <= '0;
            step <= '0;
            idx  <= '0;
            ovf  <= value_ovf;
          end
        end
        CONV: begin
          // One double-dabble step: adjust, then shift {bcd, bin} left.
          {bcd, bin} <= {dabble_adjust(bcd), bin} << 1;
          step       <= step + 5'd1;
        end
        WRITE: begin
          idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs come from registered state only; start/value never reach them.
  always_comb begin
    busy = (state != IDLE);
    dig  = 4'd0;
    pos  = IDLE_POS;
    if (state == WRITE) begin
      pos = {1'b0, idx};
      dig = bcd[{idx, 2'b00} +: 4];
    end
  end

endmodule

// File: doc/result_to_display.md
RESULT_TO_DISPLAY -- requirements
Module: result_to_display

Interface
REQ-001 Parameter: IDLE_POS, default 4'd15, position code driven whenever no digit write is in progress; must be >= 8 so the display stage ignores it.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (reset = 0) immediately forces the reset state of REQ-020.
REQ-004 start  input  1  request to convert and display `value`; sampled only in IDLE.
REQ-005 value  input  27  unsigned binary result to display.
REQ-006 busy  output  1  high whenever the state is not IDLE.
REQ-007 done  output  1  one-cycle pulse when the last digit write has been issued.
REQ-008 ovf  output  1  set when the captured value exceeds 99_999_999; held until the next accepted start.
REQ-009 dig  output  4  BCD digit for the display stage; 0 when not writing.
REQ-010 pos  output  4  digit position for the display stage (0 = units, 7 = most significant); IDLE_POS when not writing.

Function
REQ-011 The block SHALL implement the FSM IDLE -> CONV -> WRITE -> IDLE; dig and pos SHALL be decoded from registered state only, with no path from start or value.
REQ-012 In IDLE with start = 1 at edge T0, the block SHALL capture value and clear ovf; start = 1 outside IDLE SHALL be ignored.
REQ-013 If the captured value <= 99_999_999, the block SHALL enter CONV with a 5-bit step counter of 0 and a cleared 32-bit BCD register (8 nibbles).
REQ-014 CONV SHALL perform one double-dabble step per cycle: add 3 to each nibble >= 5, then shift {bcd, bin} left by 1. This gives exactly 27 steps on edges T0+1..T0+27; at edge T0+27 the state SHALL go to WRITE with digit index 0.
REQ-015 In WRITE, pos SHALL equal the digit index and dig SHALL equal BCD nibble[index]; the index SHALL increment each edge from 0 to 7, so each position is written for exactly one cycle.
REQ-016 At the edge after index 7, the block SHALL return to IDLE, assert done for exactly that one cycle, and drive pos = IDLE_POS and dig = 0.
REQ-017 Normal-path timing: pos 0..7 are valid in the cycles following edges T0+27..T0+34; done is high after edge T0+35; total latency is 35 cycles.
REQ-018 If the captured value > 99_999_999, the block SHALL skip CONV, set ovf = 1, load BCD = 0 and enter WRITE at edge T0. It then writes eight zeros in the cycles after T0..T0+7, and done is high after edge T0+8.
REQ-019 A start presented in the same cycle as done (state IDLE) SHALL be accepted normally; back-to-back conversions are permitted.

Reset
REQ-020 While reset = 0, the block SHALL hold state = IDLE, busy = 0, done = 0, ovf = 0, dig = 0, pos = IDLE_POS, BCD = 0 and all counters = 0.
REQ-021 A reset asserted during CONV or WRITE SHALL abort the operation with no further writes issued; partially written positions are left to the display stage's own reset.
REQ-022 After reset is released, the first start SHALL behave per REQ-012 with no residual state.

Verification
REQ-023 value = 12_345_678, start pulse at T0 -> (pos, dig) = (0,8), (1,7), (2,6), (3,5), (4,4), (5,3), (6,2), (7,1) in cycles T0+27..T0+34, done after T0+35, ovf = 0.
REQ-024 value = 0 and value = 99_999_999 -> eight writes of 0 and eight writes of 9 respectively, with ovf = 0.
REQ-025 value = 100_000_000 -> ovf = 1, eight writes of 0 starting in the cycle after T0, done after T0+8; ovf stays 1 until the next start.
REQ-026 start held high for the whole conversion of 12_345_678 -> exactly one set of eight writes, then a second conversion begins in the done cycle.
REQ-027 reset pulsed low at T0+10 -> busy = 0 and pos = IDLE_POS immediately, with no pos < 8 driven afterwards until a new start.
REQ-028 Idle check: with start = 0 for 100 cycles after reset -> pos = IDLE_POS and done = 0 throughout.
